// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state encoding for the uart_tx sharing logic.
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int ACC_TIMEOUT_DEF = 255;
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    GRANT = 5'b00010,
    SEND  = 5'b00100,
    DRAIN = 5'b01000,
    DONE  = 5'b10000
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    logic [IW:0] s;
    logic [IW-1:0] j;
    logic hit;
    gnt_o = '0;
    idx_o = '0;
    hit = 1'b0;
    s = '0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, ptr_i} + (IW+1)'(i);
      j = s >= (IW+1)'(N) ? IW'(s - (IW+1)'(N)) : IW'(s);
      if (!hit && req_i[j]) begin
        hit = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx serializer with an acceptance timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ACC_TIMEOUT = ACC_TIMEOUT_DEF,
  parameter int CW = 16
) (
  input  logic                   pclk_i,
  input  logic                   prst_n_i,
  input  logic [NREQ-1:0]        req_i,
  input  logic [BYTE_W*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]        ack_o,
  output logic [NREQ-1:0]        err_o,
  output logic [NREQ-1:0]        gnt_o,
  output logic [BYTE_W-1:0]      tx_pdata_o,
  output logic                   tx_pdata_valid_o,
  input  logic                   tx_pready_i,
  output logic                   busy_o
);
  localparam int IW = $clog2(NREQ);
  arb_state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, own_q, own_d, pick_idx;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d, err_q, err_d, pick_gnt;
  logic [BYTE_W-1:0] data_q, data_d;
  logic valid_q, valid_d, busy_q, busy_d;
  rr_pick #(.N(NREQ)) u_pick (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx)
  );
  assign cnt_inc = cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    ack_d = '0;
    err_d = '0;
    data_d = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (tx_pready_i && |req_i) begin
        gnt_d = pick_gnt;
        own_d = pick_idx;
        data_d = req_data_i[{pick_idx, 3'b000} +: BYTE_W];
        state_d = GRANT;
      end
      GRANT: begin
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (!tx_pready_i) begin
        valid_d = 1'b0;
        cnt_d = '0;
        state_d = DRAIN;
      end else if (cnt_inc == CW'(ACC_TIMEOUT)) begin
        valid_d = 1'b0;
        cnt_d = '0;
        err_d = gnt_q;
        state_d = DONE;
      end else begin
        cnt_d = cnt_inc;
      end
      DRAIN: if (tx_pready_i) begin
        ack_d = gnt_q;
        state_d = DONE;
      end
      DONE: begin
        gnt_d = '0;
        ptr_d = own_q == IW'(NREQ-1) ? '0 : own_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_q <= IDLE;
      ptr_q <= '0;
      own_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      ack_q <= '0;
      err_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      ack_q <= ack_d;
      err_q <= err_d;
      data_q <= data_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign gnt_o = gnt_q;
  assign tx_pdata_o = data_q;
  assign tx_pdata_valid_o = valid_q;
  assign busy_o = busy_q;
endmodule
